// File: rtl/shift_reg_feeder.sv
// shift_reg_feeder: parallel-to-serial driver for a downstream MSB-bit shift
// register. Accepts one word over valid/ready and produces exactly MSB
// enable pulses, each DIV clocks apart. The d and dir outputs are chosen so
// that the downstream register holds the accepted word when done pulses.
// Optional feature: define SHIFT_REG_FEEDER_PARITY_EN to add the 'par' output,
// which carries the even parity of the most recently accepted word.
module shift_reg_feeder #(
    parameter int MSB = 8,  // word width, must match the downstream register
    parameter int DIV = 1   // clocks per bit
) (
    input  logic           clk,
    input  logic           rst,       // asynchronous, active-low
    input  logic [MSB-1:0] in_data,
    input  logic           in_dir,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           d,
    output logic           en,
    output logic           dir,
    output logic           busy,
    output logic           done
`ifdef SHIFT_REG_FEEDER_PARITY_EN
    ,
    output logic           par
`endif
);

    localparam int CW = $clog2(MSB);
    localparam int PW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] LAST_BIT   = CW'(MSB - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t          r_state;
    logic [MSB-1:0]  r_word;
    logic            r_wdir;
    logic [CW-1:0]   r_cnt;      // index of the bit most recently driven
    logic [PW-1:0]   r_presc;    // clocks since the most recent pulse
    logic            r_ready;
    logic            r_d;
    logic            r_en;
    logic            r_dir;
    logic            r_busy;
    logic            r_done;

    state_t          w_state_nxt;
    logic [MSB-1:0]  w_word_nxt;
    logic            w_wdir_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [PW-1:0]   w_presc_nxt;
    logic            w_ready_nxt;
    logic            w_d_nxt;
    logic            w_en_nxt;
    logic            w_dir_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    logic            w_accept;
    logic [CW-1:0]   w_idx;
    logic            w_bit;
    logic            w_first_bit;

    // Handshake: r_ready is only ever set in IDLE, so it alone gates acceptance.
    assign w_accept = (r_state == ST_IDLE) && in_valid && r_ready;

    // The bit for the next pulse. Left shifts are fed MSB first and right
    // shifts LSB first, so after MSB shifts the word lands unchanged.
    assign w_idx       = r_cnt + 1'b1;
    assign w_bit       = r_wdir ? r_word[w_idx] : r_word[LAST_BIT - w_idx];
    assign w_first_bit = in_dir ? in_data[0] : in_data[MSB-1];

    // Next-state and registered-output logic for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one
        // unassigned and infer a latch.
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_wdir_nxt  = r_wdir;
        w_cnt_nxt   = r_cnt;
        w_presc_nxt = r_presc;
        w_ready_nxt = r_ready;
        w_d_nxt     = r_d;
        w_en_nxt    = 1'b0;
        w_dir_nxt   = r_dir;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                if (w_accept) begin
                    // The first pulse is raised on the accept edge itself.
                    w_state_nxt = ST_SHIFT;
                    w_word_nxt  = in_data;
                    w_wdir_nxt  = in_dir;
                    w_cnt_nxt   = '0;
                    w_presc_nxt = '0;
                    w_ready_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_en_nxt    = 1'b1;
                    w_d_nxt     = w_first_bit;
                    w_dir_nxt   = in_dir;
                end
            end

            ST_SHIFT: begin
                if (r_en && (r_cnt == LAST_BIT)) begin
                    // The edge that ends the last pulse.
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_presc_nxt = '0;
                end else if (r_presc == PRESC_LAST) begin
                    w_cnt_nxt   = w_idx;
                    w_presc_nxt = '0;
                    w_en_nxt    = 1'b1;
                    w_d_nxt     = w_bit;
                end else begin
                    // Gap cycle: d and dir hold their values.
                    w_presc_nxt = r_presc + 1'b1;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_ready_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State register and registered outputs; everything clears on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_wdir  <= 1'b0;
            r_cnt   <= '0;
            r_presc <= '0;
            r_ready <= 1'b0;
            r_d     <= 1'b0;
            r_en    <= 1'b0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed from the previous state.
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_wdir  <= w_wdir_nxt;
            r_cnt   <= w_cnt_nxt;
            r_presc <= w_presc_nxt;
            r_ready <= w_ready_nxt;
            r_d     <= w_d_nxt;
            r_en    <= w_en_nxt;
            r_dir   <= w_dir_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign in_ready = r_ready;
    assign d        = r_d;
    assign en       = r_en;
    assign dir      = r_dir;
    assign busy     = r_busy;
    assign done     = r_done;

`ifdef SHIFT_REG_FEEDER_PARITY_EN
    logic r_par;

    // Parity of the accepted word, captured on the accept edge and held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par <= 1'b0;
        end else if (w_accept) begin
            r_par <= ^in_data;
        end
    end

    assign par = r_par;
`endif

endmodule
